// File: rtl/core_fetch.sv
// Instruction-fetch stage: owns the PC, issues pipelined imem reads, buffers responses in an in-order queue.
// Define CORE_FETCH_BYPASS_EN to let a response reach decode in the same cycle when the queue is empty.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_pc_new,
  input  logic        f_pc_load,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_ir,
  input  logic        d_ready,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  logic [31:0] pc;
  logic [31:0] tail_pc;
  logic [31:0] q_pc [QDEPTH];
  logic [31:0] q_ir [QDEPTH];
  ptr_t        head, tail;
  cnt_t        count, inflight, discard;

  logic [31:0] redirect_pc;
  logic [CW:0] credit_used;
  logic        req_fire;
  logic        rsp_live;
  logic        q_valid;
  logic        pop;
  logic        enq;
  logic        byp_take;

  assign redirect_pc = f_pc_new & 32'hFFFF_FFFC;

  // Discarded responses still occupy credit: they arrive later and must not outrun the queue.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = rst_n & (credit_used < QD);
  assign imem_addr      = f_pc_load ? redirect_pc : pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is live only if it belongs to the current stream.
  assign rsp_live = imem_rsp_valid & ~f_pc_load & (discard == '0);
  assign q_valid  = (count != '0) & ~f_pc_load;
  assign pop      = q_valid & d_ready;

`ifdef CORE_FETCH_BYPASS_EN
  logic byp_valid;
  assign byp_valid = rsp_live & (count == '0);
  assign byp_take  = byp_valid & d_ready;
  assign d_valid   = q_valid | byp_valid;
  assign d_pc      = byp_valid ? tail_pc    : q_pc[head];
  assign d_ir      = byp_valid ? imem_rdata : q_ir[head];
`else
  assign byp_take  = 1'b0;
  assign d_valid   = q_valid;
  assign d_pc      = q_pc[head];
  assign d_ir      = q_ir[head];
`endif

  assign enq = rsp_live & ~byp_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      tail_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      pc       <= req_fire ? imem_addr + 32'd4 : imem_addr;
      inflight <= inflight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
      if (f_pc_load) begin
        // A response arriving in the redirect cycle is dropped here, so it is not counted again.
        discard <= inflight - cnt_t'(imem_rsp_valid);
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        tail_pc <= redirect_pc;
      end else begin
        if (imem_rsp_valid && discard != '0) discard <= discard - cnt_t'(1);
        if (rsp_live) tail_pc <= tail_pc + 32'd4;
        if (enq)      tail    <= tail + ptr_t'(1);
        if (pop)      head    <= head + ptr_t'(1);
        count <= count + cnt_t'(enq) - cnt_t'(pop);
      end
    end
  end

  // NOTE: queue storage is reset so d_pc/d_ir read as zero out of reset; it is only a few words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i] <= '0;
        q_ir[i] <= '0;
      end
    end else if (enq) begin
      q_pc[tail] <= tail_pc;
      q_ir[tail] <= imem_rdata;
    end
  end

  // The credit rule makes a full-queue enqueue unreachable.
  assert property (@(posedge clk) disable iff (!rst_n) !(enq && count == cnt_t'(QDEPTH)));

endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch: in-order memory model with programmable latency, decode-side log.
// Expected values are hand-derived; CORE_FETCH_BYPASS_EN shortens the response-to-decode latency by one.
module tb_core_fetch;

`ifdef CORE_FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] f_pc_new = '0;
  logic        f_pc_load = 1'b0;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_ir;
  logic        d_ready = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;

  core_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .f_pc_new       (f_pc_new),
    .f_pc_load      (f_pc_load),
    .d_valid        (d_valid),
    .d_pc           (d_pc),
    .d_ir           (d_ir),
    .d_ready        (d_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F13;
  endfunction

  // Memory model and observation logs
  logic [31:0] pq_addr[$];
  int          pq_due[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_acc = 0;
  logic [31:0] con_pc[$];
  logic [31:0] con_ir[$];
  int          con_cyc[$];

  logic        s_req_valid;
  logic [31:0] s_addr;
  logic        s_d_valid;
  logic [31:0] s_d_pc;
  logic [31:0] s_d_ir;

  // Called at a negedge: samples the current cycle, then moves to the next negedge and presents any due response.
  task automatic tick();
    #1;
    s_req_valid = imem_req_valid;
    s_addr      = imem_addr;
    s_d_valid   = d_valid;
    s_d_pc      = d_pc;
    s_d_ir      = d_ir;
    if (imem_req_valid && imem_req_ready) begin
      pq_addr.push_back(imem_addr);
      pq_due.push_back(cyc + lat);
      n_acc++;
    end
    if (d_valid && d_ready) begin
      con_pc.push_back(d_pc);
      con_ir.push_back(d_ir);
      con_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
    if (pq_due.size() > 0 && pq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_word(pq_addr[0]);
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    con_pc.delete();
    con_ir.delete();
    con_cyc.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_d_valid"},   {31'd0, d_valid},        32'd0);
    check({tag, "_d_pc"},      d_pc,                    32'd0);
    check({tag, "_d_ir"},      d_ir,                    32'd0);
    pq_addr.delete();
    pq_due.delete();
    clear_log();
    n_acc          = 0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    f_pc_load      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 1;
  endtask

  // Checks the first n consumed entries form a consecutive stream starting at base.
  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    check({tag, "_len_ok"}, {31'd0, con_pc.size() >= n}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < con_pc.size()) begin
        check($sformatf("%s_pc%0d", tag, i), con_pc[i], base + 32'(4 * i));
        check($sformatf("%s_ir%0d", tag, i), con_ir[i], mem_word(base + 32'(4 * i)));
      end
    end
  endtask

  initial begin
    int bad;
    #3;

    // Reset release, L=1, decode always ready: one instruction per cycle from cycle 3.
    do_reset("rst0");
    lat = 1; d_ready = 1'b1; imem_req_ready = 1'b1;
    tick();
    check("t1_first_req_valid", {31'd0, s_req_valid}, 32'd1);
    check("t1_first_req_addr",  s_addr,               32'h0);
    tick();
    check("t1_cyc2_d_valid", {31'd0, s_d_valid}, 32'(BYP));
    ticks(8);
    check("t1_n_consumed", con_pc.size(), 32'(8 + BYP));
    if (con_cyc.size() > 0) check("t1_first_valid_cyc", con_cyc[0], 32'(3 - BYP));
    for (int i = 1; i < con_cyc.size(); i++)
      check($sformatf("t1_back2back%0d", i), con_cyc[i], con_cyc[i-1] + 1);
    check_stream("t1", 32'h0, 8);

    // Mid-run reset, then decode stalled: exactly QDEPTH requests, head held at 0x0.
    do_reset("rst1");
    lat = 1; d_ready = 1'b0; imem_req_ready = 1'b1;
    ticks(5);
    check("t2_head_pc_mid", s_d_pc, 32'h0);
    ticks(5);
    check("t2_n_accepted",   n_acc,                32'd4);
    check("t2_req_valid_lo", {31'd0, s_req_valid}, 32'd0);
    check("t2_d_valid",      {31'd0, s_d_valid},   32'd1);
    check("t2_head_pc",      s_d_pc,               32'h0);
    check("t2_head_ir",      s_d_ir,               mem_word(32'h0));
    d_ready = 1'b1;
    ticks(10);
    check_stream("t2", 32'h0, 6);

    // L=3, three in flight (0,4,8); redirect coincides with response 0 and a live request at 0x100.
    do_reset("rst2");
    lat = 3; d_ready = 1'b1; imem_req_ready = 1'b1;
    ticks(3);
    f_pc_load = 1'b1; f_pc_new = 32'h100;
    tick();
    check("t3_redir_req_valid", {31'd0, s_req_valid}, 32'd1);
    check("t3_redir_addr",      s_addr,               32'h100);
    check("t3_redir_d_valid",   {31'd0, s_d_valid},   32'd0);
    f_pc_load = 1'b0;
    clear_log();
    ticks(12);
    if (con_cyc.size() > 0) check("t3_first_valid_cyc", con_cyc[0], 32'(8 - BYP));
    bad = 0;
    foreach (con_pc[i]) if (con_pc[i] < 32'h100) bad++;
    check("t3_old_stream_seen", bad, 0);
    check_stream("t3", 32'h100, 4);

    // Back-to-back redirects: only the 0x300 stream may reach decode.
    f_pc_load = 1'b1; f_pc_new = 32'h200;
    tick();
    check("t4_redir_d_valid", {31'd0, s_d_valid}, 32'd0);
    check("t4_addr_200",      s_addr,             32'h200);
    f_pc_new = 32'h300;
    tick();
    check("t4_addr_300", s_addr, 32'h300);
    f_pc_load = 1'b0;
    clear_log();
    ticks(16);
    bad = 0;
    foreach (con_pc[i]) if (con_pc[i] < 32'h300) bad++;
    check("t4_stale_seen", bad, 0);
    check_stream("t4", 32'h300, 3);

    // Misaligned target is word-aligned on the fetch address and in decode.
    f_pc_load = 1'b1; f_pc_new = 32'h40E;
    tick();
    check("t5_aligned_addr", s_addr, 32'h40C);
    f_pc_load = 1'b0;
    clear_log();
    ticks(12);
    check_stream("t5", 32'h40C, 2);

    // Redirect while memory refuses requests: target is held until accepted.
    imem_req_ready = 1'b0;
    ticks(2);
    f_pc_load = 1'b1; f_pc_new = 32'h500;
    tick();
    f_pc_load = 1'b0;
    tick();
    check("t6_held_addr", s_addr, 32'h500);
    imem_req_ready = 1'b1;
    clear_log();
    ticks(12);
    check_stream("t6", 32'h500, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
